// File: rtl/AluCtrlSig_pkg.sv
// Shared ALU control constants, stimulus FSM state type and
// encode/LFSR helpers used by the instruction stimulus generator.
package AluCtrlSig_pkg;

    localparam logic [5:0] ADD_op  = 6'd0;
    localparam logic [5:0] ADDI_op = 6'd8;

    localparam logic [5:0] FUNCT_ADD = 6'd2;
    localparam logic [5:0] FUNCT_SUB = 6'd6;
    localparam logic [5:0] FUNCT_AND = 6'd0;
    localparam logic [5:0] FUNCT_OR  = 6'd1;
    localparam logic [5:0] FUNCT_NOR = 6'd12;
    localparam logic [5:0] FUNCT_SLT = 6'd7;
    localparam logic [5:0] FUNCT_XOR = 6'd13;

    // Packed: element [0] is the rightmost entry.
    localparam logic [7:0][5:0] FUNCT_TBL = {
        FUNCT_ADD, FUNCT_XOR, FUNCT_SLT, FUNCT_NOR,
        FUNCT_OR,  FUNCT_AND, FUNCT_SUB, FUNCT_ADD
    };

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } stim_state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [31:0] encode_inst(input logic [31:0] s);
        logic [4:0] rd;
        logic [4:0] rt;
        rd = (s[15:11] == 5'd0) ? 5'd1 : s[15:11];
        rt = (s[20:16] == 5'd0) ? 5'd1 : s[20:16];
        if (!s[31])
            return {ADD_op, s[25:21], s[20:16], rd, 5'd0, FUNCT_TBL[s[2:0]]};
        return {ADDI_op, s[25:21], rt, s[15:0]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR with seed load (zero seed maps to 1)
// and an advance enable; reusable by other random-stimulus blocks.
module lfsr32_galois
    import AluCtrlSig_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load)
            state_d = (seed == 32'd0) ? 32'd1 : seed;
        else if (adv)
            state_d = lfsr_next(state_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= 32'd1;
        else
            state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/inst_stim_gen.sv
// Issues pseudo-random R-type/ADDI instructions with a pcEn strobe,
// waits for OpDone or a timeout, and tallies pass/fail/issued counts.
module inst_stim_gen
    import AluCtrlSig_pkg::*;
#(
    parameter int NUM_INST = 16,
    parameter int TIMEOUT  = 8,
    parameter int GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] seed,
    input  logic        OpDone,
    output logic [31:0] inst,
    output logic        pcEn,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic [15:0] issued_cnt
);

    stim_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pass_q, pass_d;
    logic [15:0] fail_q, fail_d;
    logic [15:0] issued_q, issued_d;
    logic [31:0] inst_q, inst_d;
    logic        pcen_q, pcen_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        lfsr_load;
    logic        lfsr_adv;
    logic [31:0] lfsr_state;

    lfsr32_galois u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed),
        .adv   (lfsr_adv),
        .state (lfsr_state)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        issued_d  = issued_q;
        inst_d    = inst_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    pass_d    = 16'd0;
                    fail_d    = 16'd0;
                    issued_d  = 16'd1;
                    // The LFSR loads on this edge, so encode straight from the seed.
                    inst_d    = encode_inst((seed == 32'd0) ? 32'd1 : seed);
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lfsr_adv = 1'b1;
                cnt_d    = 16'd0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (OpDone) begin
                    pass_d  = sat_inc(pass_q);
                    cnt_d   = 16'd0;
                    state_d = ST_GAP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    fail_d  = sat_inc(fail_q);
                    cnt_d   = 16'd0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'(GAP - 1)) begin
                    if (issued_q == 16'(NUM_INST)) begin
                        state_d = ST_DONE;
                    end else begin
                        issued_d = sat_inc(issued_q);
                        inst_d   = encode_inst(lfsr_state);
                        state_d  = ST_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pcen_d = (state_d == ST_ISSUE);
        busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT) ||
                 (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            pass_q   <= 16'd0;
            fail_q   <= 16'd0;
            issued_q <= 16'd0;
            inst_q   <= 32'd0;
            pcen_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            issued_q <= issued_d;
            inst_q   <= inst_d;
            pcen_q   <= pcen_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign inst       = inst_q;
    assign pcEn       = pcen_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
    assign issued_cnt = issued_q;

endmodule

// File: tb/tb_inst_stim_gen.sv
// Self-checking bench for inst_stim_gen against a cycle-schedule
// reference model built from the instruction protocol rules.
module tb_inst_stim_gen;

  localparam int NUM_INST = 4;
  localparam int TIMEOUT  = 8;
  localparam int GAP      = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic        OpDone;
  logic [31:0] inst;
  logic        pcEn;
  logic        busy;
  logic        done;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic [15:0] issued_cnt;

  int errors = 0;
  int checks = 0;
  int lat [NUM_INST];
  logic [31:0] first_inst;
  int ftbl [8] = '{2, 6, 0, 1, 12, 7, 13, 2};

  inst_stim_gen #(
    .NUM_INST (NUM_INST),
    .TIMEOUT  (TIMEOUT),
    .GAP      (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .OpDone     (OpDone),
    .inst       (inst),
    .pcEn       (pcEn),
    .busy       (busy),
    .done       (done),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .issued_cnt (issued_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] m_next(input logic [31:0] s);
    if (s % 32'd2 == 32'd1)
      return (s / 32'd2) ^ 32'h8020_0003;
    return s / 32'd2;
  endfunction

  function automatic logic [31:0] m_enc(input logic [31:0] s);
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] rd;
    rs = (s >> 21) & 32'd31;
    rt = (s >> 16) & 32'd31;
    rd = (s >> 11) & 32'd31;
    if (s < 32'h8000_0000) begin
      if (rd == 32'd0) rd = 32'd1;
      return (rs << 21) | (rt << 16) | (rd << 11) |
             32'(ftbl[int'(s & 32'd7)]);
    end
    if (rt == 32'd0) rt = 32'd1;
    return 32'h2000_0000 | (rs << 21) | (rt << 16) |
           (s & 32'h0000_FFFF);
  endfunction

  task automatic run_seq(input logic [31:0] sd, input bit extra,
                         input string tag);
    logic [31:0] s;
    logic [31:0] exp_inst [NUM_INST];
    bit iss [0:127];
    bit pul [0:127];
    int t;
    int t_end;
    int np;
    int nf;
    int ni;
    for (int k = 0; k < 128; k++) begin
      iss[k] = 1'b0;
      pul[k] = 1'b0;
    end
    s  = (sd == 32'd0) ? 32'd1 : sd;
    t  = 0;
    np = 0;
    nf = 0;
    for (int i = 0; i < NUM_INST; i++) begin
      exp_inst[i] = m_enc(s);
      s = m_next(s);
      iss[t] = 1'b1;
      if (lat[i] >= 1 && lat[i] <= TIMEOUT) begin
        np++;
        pul[t + lat[i]] = 1'b1;
        if (extra) pul[t + lat[i] + 1] = 1'b1;
        t += 1 + lat[i] + GAP;
      end else begin
        nf++;
        if (lat[i] > 0) pul[t + lat[i]] = 1'b1;
        t += 1 + TIMEOUT + GAP;
      end
    end
    t_end = t;
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ni    = 0;
    for (int k = 0; k <= t_end; k++) begin
      if (k > 0) @(negedge clk);
      OpDone = pul[k];
      if (k == 0) first_inst = inst;
      checks++;
      if (pcEn !== iss[k]) begin
        errors++;
        $display("FAIL %s pcEn cyc=%0d got=%b exp=%b",
                 tag, k, pcEn, iss[k]);
      end
      if (iss[k] && ni < NUM_INST) begin
        checks++;
        if (inst !== exp_inst[ni]) begin
          errors++;
          $display("FAIL %s inst#%0d got=%h exp=%h",
                   tag, ni, inst, exp_inst[ni]);
        end
        checks++;
        if (issued_cnt !== 16'(ni + 1)) begin
          errors++;
          $display("FAIL %s issued#%0d got=%0d exp=%0d",
                   tag, ni, issued_cnt, ni + 1);
        end
        ni++;
      end
      checks++;
      if (busy !== (k < t_end)) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b",
                 tag, k, busy, k < t_end);
      end
      checks++;
      if (done !== (k == t_end)) begin
        errors++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b",
                 tag, k, done, k == t_end);
      end
    end
    OpDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      OpDone = (k == 1);
    end
    OpDone = 1'b0;
    checks++;
    if (pass_cnt !== 16'(np)) begin
      errors++;
      $display("FAIL %s pass_cnt got=%0d exp=%0d", tag, pass_cnt, np);
    end
    checks++;
    if (fail_cnt !== 16'(nf)) begin
      errors++;
      $display("FAIL %s fail_cnt got=%0d exp=%0d", tag, fail_cnt, nf);
    end
    checks++;
    if (issued_cnt !== 16'(NUM_INST)) begin
      errors++;
      $display("FAIL %s issued_final got=%0d exp=%0d",
               tag, issued_cnt, NUM_INST);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_hold got=%b/%b exp=1/0", tag, done, busy);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (inst !== 32'd0 || pcEn !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs got inst=%h pcEn=%b busy=%b done=%b exp=0",
               tag, inst, pcEn, busy, done);
    end
    checks++;
    if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 ||
        issued_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s counters got %0d/%0d/%0d exp=0/0/0",
               tag, pass_cnt, fail_cnt, issued_cnt);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    seed   = 32'd0;
    OpDone = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");
  endtask

  task automatic test_first_inst();
    for (int i = 0; i < NUM_INST; i++) lat[i] = 4;
    run_seq(32'h1, 1'b0, "seed1_pass");
    checks++;
    if (first_inst !== 32'h0000_0806) begin
      errors++;
      $display("FAIL first_inst got=%h exp=00000806", first_inst);
    end
  endtask

  task automatic test_all_timeout();
    for (int i = 0; i < NUM_INST; i++) lat[i] = 0;
    run_seq($urandom, 1'b0, "timeout");
  endtask

  task automatic test_timeout_edge();
    for (int i = 0; i < NUM_INST; i++) lat[i] = TIMEOUT;
    run_seq($urandom, 1'b1, "edge_gap");
    lat[0] = TIMEOUT + 1;
    lat[1] = 3;
    lat[2] = TIMEOUT + 3;
    lat[3] = 1;
    run_seq($urandom, 1'b1, "mixed");
  endtask

  task automatic test_seed_zero();
    for (int i = 0; i < NUM_INST; i++) lat[i] = 4;
    run_seq(32'h0, 1'b0, "seed0");
    checks++;
    if (first_inst !== 32'h0000_0806) begin
      errors++;
      $display("FAIL seed0_first got=%h exp=00000806", first_inst);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_INST; i++)
        lat[i] = int'($urandom_range(0, TIMEOUT + 3));
      run_seq($urandom, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] sd;
    sd = $urandom;
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("after_abort");
    for (int i = 0; i < NUM_INST; i++) lat[i] = 4;
    run_seq(sd, 1'b0, "rerun");
    checks++;
    if (first_inst !== m_enc((sd == 32'd0) ? 32'd1 : sd)) begin
      errors++;
      $display("FAIL rerun_first got=%h exp=%h", first_inst,
               m_enc((sd == 32'd0) ? 32'd1 : sd));
    end
  endtask

  initial begin
    test_reset();
    test_first_inst();
    test_all_timeout();
    test_timeout_edge();
    test_seed_zero();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_stim_gen.md
Name: inst_stim_gen

Overview:
Instruction stimulus generator that drives the instruction-issue side of the MIPS check protocol. It produces pseudo-random R-type ALU and ADDI instructions from an LFSR and presents each one on inst with a one-cycle pcEn strobe. It then waits for the checker's OpDone pulse, or a timeout, and keeps pass/fail/issued counts. It sits in the Veloce testbench between the program sequencer and both the MIPS DUT fetch path and the check block.

Parameters:
NUM_INST, 16, instructions issued per run (1..65535)
TIMEOUT, 8, cycles in WAIT without OpDone before the instruction is counted as failed (≥5)
GAP, 2, idle cycles with pcEn low between the end of one instruction and the next issue (≥1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  level; sampled in IDLE/DONE to begin a run
seed  input  32  LFSR seed, loaded on accepted start; 0 is replaced by 32'h1
OpDone  input  1  checker result pulse (1 = match)
inst  output  32  instruction word, valid while pcEn=1
pcEn  output  1  issue strobe, one cycle per instruction
busy  output  1  high in ISSUE/WAIT/GAP
done  output  1  high in DONE
pass_cnt  output  16  instructions that received OpDone
fail_cnt  output  16  instructions that timed out
issued_cnt  output  16  instructions issued this run

Behaviour:
- Reset (async, any state): state=IDLE; inst=0, pcEn=0, busy=0, done=0; all counters 0; lfsr=32'h1.
- FSM states: IDLE, ISSUE, WAIT, GAP, DONE.
- IDLE/DONE + start=1: load lfsr=seed (0→1), clear counters, go to ISSUE. Counters hold their values in DONE until the next accepted start. start in any other state is ignored.
- ISSUE (exactly 1 cycle): pcEn=1, inst=encode(lfsr); issued_cnt++; lfsr advances; next state is WAIT with wait_cnt=0.
- Encode, using lfsr state s before the advance:
  - s[31]=0 → R-type: opcode=ADD_op, rs=s[25:21], rt=s[20:16], rd=s[15:11] (0→1), shamt=0, funct=FUNCT_TBL[s[2:0]].
  - s[31]=1 → ADDI_op: rs=s[25:21], rt=s[20:16] (0→1), imm=s[15:0].
- FUNCT_TBL index 0..7 = ADD 2, SUB 6, AND 0, OR 1, NOR 12, SLT 7, XOR 13, ADD 2.
- LFSR: 32-bit Galois, right shift. If s[0]=1, next = (s>>1)^32'h80200003; otherwise next = s>>1.
- WAIT: pcEn=0, inst holds its last value.
  - OpDone=1 → pass_cnt++, go to GAP.
  - Otherwise wait_cnt++. When wait_cnt reaches TIMEOUT-1 without OpDone → fail_cnt++, go to GAP.
  - If OpDone arrives on the timeout cycle itself, it counts as a pass (pass has priority).
- OpDone seen outside WAIT is ignored and never counted.
- GAP: pcEn=0 for GAP cycles. Then go to DONE if issued_cnt==NUM_INST, else to ISSUE.
- Cycles per instruction = 1 + (OpDone latency or TIMEOUT) + GAP. An OpDone latency of 4 cycles after pcEn matches the check block.
- Counters saturate at 16'hFFFF. Invariant in DONE: pass_cnt + fail_cnt == issued_cnt == NUM_INST.
- rst asserted mid-run: immediate abort to IDLE with the reset values above; no partial counts are retained.

Decomposition:
- AluCtrlSig_pkg (shared) holds the opcode constants (ADD_op, ADDI_op), the funct values, and a new typedef stim_state_e for the FSM.
- FUNCT_TBL lives in the package as a localparam array.
- Sub-module lfsr32_galois (clk, rst, load, seed, adv, state) is factored out for reuse by later random-stimulus blocks.

Test Plan:
- rst then start with seed=32'h1 → first pcEn cycle has inst=32'h00000806 (R-type, rs=0, rt=0, rd=1, SUB); issued_cnt=1.
- NUM_INST=4, OpDone driven 4 cycles after each pcEn → pass_cnt=4, fail_cnt=0, done=1 exactly 4*(1+4+2)=28 cycles after the first ISSUE.
- NUM_INST=4, OpDone tied 0 → fail_cnt=4, pass_cnt=0, done after 4*(1+8+2)=44 cycles; pcEn pulses spaced 11 cycles apart.
- OpDone asserted on the final timeout cycle → counted as pass; an OpDone pulse during GAP → no counter change.
- seed=0 → behaves identically to seed=32'h1 (same first inst 32'h00000806).
- rst pulsed during WAIT of the 2nd instruction → outputs and counters 0, state IDLE; a new start re-runs from the seed.
